// File: rtl/multiplier_sequencer.sv
// multiplier_sequencer
//
// Control and buffering stage for a shift-add multiplier datapath. Takes an
// operand pair over valid/ready, registers it, drives the datapath through one
// init cycle and N shift cycles, then captures the 2N-bit product into a
// one-entry output buffer with valid/ready backpressure.
//
// State table:
//   IDLE    | ready for a new operand pair
//   INIT    | do_init pulse: datapath clears a, loads q
//   SHIFT   | do_shift every cycle, N cycles total
//   CAPTURE | datapath holds product; wait for a free output buffer
//
// Ports:
//   clock, n_reset                      rising-edge clock, async active-low reset
//   in_valid, in_ready                  operand handshake
//   in_multiplicand, in_multiplier      offered operands (N bits)
//   do_init, do_shift                   datapath control strobes
//   multiplicand, multiplier            registered operands to the datapath
//   product                             datapath result {a, q} (2N bits)
//   out_valid, out_ready, out_product   buffered result handshake
//   busy                                high whenever not IDLE

module multiplier_sequencer #(
    parameter int N = 4
) (
    input  logic             clock,
    input  logic             n_reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_multiplicand,
    input  logic [N-1:0]     in_multiplier,
    output logic             do_init,
    output logic             do_shift,
    output logic [N-1:0]     multiplicand,
    output logic [N-1:0]     multiplier,
    input  logic [2*N-1:0]   product,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N-1:0]   out_product,
    output logic             busy
);

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST_SHIFT = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        INIT    = 2'd1,
        SHIFT   = 2'd2,
        CAPTURE = 2'd3
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] count;
    logic          accept;
    logic          buffer_free;
    logic          load_out;

    // The buffer can take a new product when it is empty or is being drained
    // on this same edge.
    assign buffer_free = !out_valid || out_ready;

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        busy       = 1'b1;
        do_init    = 1'b0;
        do_shift   = 1'b0;
        accept     = 1'b0;
        load_out   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = INIT;
                end
            end
            INIT: begin
                do_init    = 1'b1;
                state_next = SHIFT;
            end
            SHIFT: begin
                do_shift = 1'b1;
                if (count == LAST_SHIFT) begin
                    state_next = CAPTURE;
                end
            end
            CAPTURE: begin
                if (buffer_free) begin
                    load_out   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            count <= '0;
        end else if (state == INIT) begin
            count <= '0;
        end else if (state == SHIFT) begin
            count <= count + CW'(1);
        end
    end

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            multiplicand <= '0;
            multiplier   <= '0;
        end else if (accept) begin
            multiplicand <= in_multiplicand;
            multiplier   <= in_multiplier;
        end
    end

    // A load wins over a drain on the same edge, so out_valid stays high and
    // the new product replaces the consumed one.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            out_valid   <= 1'b0;
            out_product <= '0;
        end else if (load_out) begin
            out_valid   <= 1'b1;
            out_product <= product;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_multiplier_sequencer.sv
// Testbench for multiplier_sequencer: two instances (N=4 and N=8), each wired
// to a behavioural shift-add datapath; results compared against plain a*b.

module tb_multiplier_sequencer;

    logic clock = 1'b0;
    logic n_reset = 1'b0;
    always #5 clock = ~clock;

    int         w_sel = 4;
    logic       iv = 1'b0;
    logic       ord = 1'b0;
    logic [7:0] ia = '0;
    logic [7:0] ib = '0;

    int checks = 0;
    int failures = 0;

    // N=4 instance
    logic       in_valid4, in_ready4, do_init4, do_shift4, ov4, busy4, out_ready4;
    logic [3:0] md4, mr4;
    logic [7:0] prod4, op4;
    logic [3:0] a4, q4;
    logic [4:0] sum5;

    assign in_valid4  = iv && (w_sel == 4);
    assign out_ready4 = ord && (w_sel == 4);

    multiplier_sequencer #(.N(4)) dut4 (
        .clock(clock), .n_reset(n_reset),
        .in_valid(in_valid4), .in_ready(in_ready4),
        .in_multiplicand(ia[3:0]), .in_multiplier(ib[3:0]),
        .do_init(do_init4), .do_shift(do_shift4),
        .multiplicand(md4), .multiplier(mr4),
        .product(prod4),
        .out_valid(ov4), .out_ready(out_ready4), .out_product(op4),
        .busy(busy4)
    );

    assign sum5  = {1'b0, a4} + (q4[0] ? {1'b0, md4} : 5'd0);
    assign prod4 = {a4, q4};
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            a4 <= '0; q4 <= '0;
        end else if (do_init4) begin
            a4 <= '0; q4 <= mr4;
        end else if (do_shift4) begin
            {a4, q4} <= {sum5, q4[3:1]};
        end
    end

    // N=8 instance
    logic        in_valid8, in_ready8, do_init8, do_shift8, ov8, busy8, out_ready8;
    logic [7:0]  md8, mr8;
    logic [15:0] prod8, op8;
    logic [7:0]  a8, q8;
    logic [8:0]  sum9;

    assign in_valid8  = iv && (w_sel == 8);
    assign out_ready8 = ord && (w_sel == 8);

    multiplier_sequencer #(.N(8)) dut8 (
        .clock(clock), .n_reset(n_reset),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .in_multiplicand(ia), .in_multiplier(ib),
        .do_init(do_init8), .do_shift(do_shift8),
        .multiplicand(md8), .multiplier(mr8),
        .product(prod8),
        .out_valid(ov8), .out_ready(out_ready8), .out_product(op8),
        .busy(busy8)
    );

    assign sum9  = {1'b0, a8} + (q8[0] ? {1'b0, md8} : 9'd0);
    assign prod8 = {a8, q8};
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            a8 <= '0; q8 <= '0;
        end else if (do_init8) begin
            a8 <= '0; q8 <= mr8;
        end else if (do_shift8) begin
            {a8, q8} <= {sum9, q8[7:1]};
        end
    end

    // Observation of the instance under test
    logic        s_ir, s_busy, s_init, s_shift, s_ov;
    logic [15:0] s_op, s_md;
    always_comb begin
        if (w_sel == 8) begin
            s_ir = in_ready8; s_busy = busy8; s_init = do_init8; s_shift = do_shift8;
            s_ov = ov8; s_op = op8; s_md = {8'd0, md8};
        end else begin
            s_ir = in_ready4; s_busy = busy4; s_init = do_init4; s_shift = do_shift4;
            s_ov = ov4; s_op = {8'd0, op4}; s_md = {12'd0, md4};
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Offer an operand pair and return just after the accepting edge (cycle 1).
    task automatic accept(input logic [7:0] a, input logic [7:0] b);
        int i;
        iv = 1'b1; ia = a; ib = b;
        i = 0;
        while (!s_ir && i < 40) begin
            tick();
            i++;
        end
        check("accept_ready", s_ir, 1);
        tick();
        iv = 1'b0;
    endtask

    // From cycle 1, wait for out_valid; check product, shift pulses, latency.
    task automatic wait_result(input logic [31:0] exp, input bit chk_lat);
        int lat;
        int pulses;
        bit got;
        lat = 0; pulses = 0; got = 0;
        while (!got && lat < 40) begin
            lat++;
            check("init_shift_exclusive", s_init & s_shift, 0);
            if (s_shift) pulses++;
            if (s_ov) got = 1;
            else tick();
        end
        check("result_seen", got, 1);
        check("product", s_op, exp);
        check("shift_pulses", pulses, w_sel);
        if (chk_lat) check("latency", lat, w_sel + 3);
    endtask

    initial begin
        logic [7:0] ra, rb;

        repeat (2) @(posedge clock);
        #1 n_reset = 1'b1;
        #1;
        check("rst_in_ready", s_ir, 1);
        check("rst_busy", s_busy, 0);
        check("rst_out_valid", s_ov, 0);
        check("rst_out_product", s_op, 0);
        check("rst_do_init", s_init, 0);
        check("rst_do_shift", s_shift, 0);
        check("rst_multiplicand", s_md, 0);
        check("rst_out_valid8", ov8, 0);
        tick();

        // 3x5 cycle-by-cycle
        accept(8'd3, 8'd5);
        check("c1_do_init", s_init, 1);
        check("c1_do_shift", s_shift, 0);
        check("c1_busy", s_busy, 1);
        check("c1_in_ready", s_ir, 0);
        for (int c = 2; c <= 5; c++) begin
            tick();
            check("shift_cycle_do_shift", s_shift, 1);
            check("shift_cycle_do_init", s_init, 0);
            check("shift_cycle_md", s_md, 3);
        end
        tick();
        check("c6_do_shift", s_shift, 0);
        check("c6_out_valid", s_ov, 0);
        check("c6_busy", s_busy, 1);
        tick();
        check("c7_out_valid", s_ov, 1);
        check("c7_out_product", s_op, 15);
        check("c7_in_ready", s_ir, 1);
        ord = 1'b1; tick();
        check("drained", s_ov, 0);

        // Streaming with out_ready held high
        accept(8'd15, 8'd15); wait_result(225, 1);
        accept(8'd0, 8'd9);   wait_result(0, 1);
        for (int k = 0; k < 8; k++) begin
            ra = 8'($urandom_range(0, 15));
            rb = 8'($urandom_range(0, 15));
            accept(ra, rb);
            wait_result(32'(ra) * 32'(rb), 1);
        end
        tick();
        check("stream_drained", s_ov, 0);

        // Backpressure: 2x7 held, 6x6 stalls in CAPTURE
        ord = 1'b0;
        accept(8'd2, 8'd7); wait_result(14, 1);
        accept(8'd6, 8'd6);
        for (int c = 0; c < 10; c++) begin
            check("bp_hold_product", s_op, 14);
            check("bp_hold_valid", s_ov, 1);
            tick();
        end
        check("bp_stall_in_ready", s_ir, 0);
        check("bp_stall_busy", s_busy, 1);
        ord = 1'b1; tick(); ord = 1'b0;
        check("bp_reload_valid", s_ov, 1);
        check("bp_reload_product", s_op, 36);
        check("bp_reload_busy", s_busy, 0);
        ord = 1'b1; tick();
        check("bp_final_drain", s_ov, 0);

        // in_valid during SHIFT is ignored
        accept(8'd3, 8'd6);
        tick();
        iv = 1'b1; ia = 8'd5; ib = 8'd5;
        begin
            int i;
            i = 0;
            while (!s_ov && i < 40) begin
                check("ign_md_stable", s_md, 3);
                check("ign_in_ready", s_ir, 0);
                tick();
                i++;
            end
        end
        check("ign_result_valid", s_ov, 1);
        check("ign_result", s_op, 18);
        check("ign_now_ready", s_ir, 1);
        tick();
        iv = 1'b0;
        check("ign_second_md", s_md, 5);
        wait_result(25, 0);
        tick();

        // Async reset in third SHIFT cycle, with a buffered result pending
        ord = 1'b0;
        accept(8'd2, 8'd3); wait_result(6, 1);
        accept(8'd4, 8'd5);
        tick(); tick(); tick();
        check("pre_reset_shift", s_shift, 1);
        #1 n_reset = 1'b0;
        #1;
        check("mid_rst_out_valid", s_ov, 0);
        check("mid_rst_busy", s_busy, 0);
        check("mid_rst_in_ready", s_ir, 1);
        check("mid_rst_do_shift", s_shift, 0);
        check("mid_rst_out_product", s_op, 0);
        #1 n_reset = 1'b1;
        tick();
        ord = 1'b1;
        accept(8'd4, 8'd4); wait_result(16, 1);
        tick();

        // N=8
        w_sel = 8;
        #1;
        accept(8'd255, 8'd255); wait_result(65025, 1);
        for (int k = 0; k < 4; k++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            accept(ra, rb);
            wait_result(32'(ra) * 32'(rb), 1);
        end
        tick();
        check("n8_drained", s_ov, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
